car_traffic_gen: RTL and testbench

//  Produces the per-cycle left-corner X positions of the six road cars. These are the o_CarN_X values

---
 rtl/car_traffic_gen_if.sv | 28 ++
 rtl/car_traffic_gen.sv | 125 ++++++++++++
 tb/tb_car_traffic_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/car_traffic_gen_if.sv
// Control/position bundle between game control, car_traffic_gen and the collision/render blocks.
// The master drives the control pulses and collision flag; the slave returns car positions and status.
interface car_traffic_gen_if;
  logic       i_Start;
  logic       i_Restart;
  logic       i_Has_Collided;
  logic [9:0] o_Car1_X;
  logic [9:0] o_Car2_X;
  logic [9:0] o_Car3_X;
  logic [9:0] o_Car4_X;
  logic [9:0] o_Car5_X;
  logic [9:0] o_Car6_X;
  logic       o_Move_Tick;
  logic       o_Frozen;
  logic       o_Running;

  modport master (
    output i_Start, i_Restart, i_Has_Collided,
    input  o_Car1_X, o_Car2_X, o_Car3_X, o_Car4_X, o_Car5_X, o_Car6_X,
    input  o_Move_Tick, o_Frozen, o_Running
  );

  modport slave (
    input  i_Start, i_Restart, i_Has_Collided,
    output o_Car1_X, o_Car2_X, o_Car3_X, o_Car4_X, o_Car5_X, o_Car6_X,
    output o_Move_Tick, o_Frozen, o_Running
  );
endinterface

// File: rtl/car_traffic_gen.sv
// Six-car horizontal traffic generator: moves cars on each prescaled move tick, wraps at the
// screen edge, and freezes traffic for a fixed number of ticks after a collision.
//
//  state  | meaning
//  IDLE   | cars parked at start positions, waiting for i_Start
//  RUN    | cars advance by their speed on every move tick
//  FROZEN | cars held after a collision until the freeze counter expires
module car_traffic_gen #(
  parameter int          SCREEN_WIDTH = 640,
  parameter int          TICK_DIV     = 250000,
  parameter int          FREEZE_TICKS = 50,
  parameter logic [59:0] CAR_START_X  = {10'd560, 10'd420, 10'd300, 10'd180, 10'd90, 10'd10},
  parameter logic [23:0] CAR_SPEED    = {4'd6, 4'd2, 4'd4, 4'd3, 4'd5, 4'd1},
  parameter logic [5:0]  CAR_DIR      = 6'b101010
) (
  input logic             i_Clk,
  input logic             i_Rst_n,
  car_traffic_gen_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FREEZE_TICKS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [FW-1:0] frz_cnt;
  logic [9:0]    car_x [6];
  logic          move_tick;
  logic          frozen;
  logic          running;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Start values beyond the screen are folded back in at elaboration.
  function automatic logic [9:0] start_x(input int k);
    int v;
    v = int'(CAR_START_X[10*k +: 10]) % SCREEN_WIDTH;
    return 10'(v);
  endfunction

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [3:0] s, input logic d);
    logic [10:0] n;
    if (d) begin
      n = {1'b0, x} + {7'd0, s};
      if (n >= 11'(SCREEN_WIDTH)) n = n - 11'(SCREEN_WIDTH);
    end else if (x < {6'd0, s}) begin
      n = {1'b0, x} + 11'(SCREEN_WIDTH) - {7'd0, s};
    end else begin
      n = {1'b0, x} - {7'd0, s};
    end
    return n[9:0];
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      frz_cnt   <= '0;
      move_tick <= 1'b0;
      frozen    <= 1'b0;
      running   <= 1'b0;
      for (int k = 0; k < 6; k++) car_x[k] <= start_x(k);
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      move_tick <= tick;
      if (bus.i_Restart) begin
        state   <= IDLE;
        frz_cnt <= '0;
        frozen  <= 1'b0;
        running <= 1'b0;
        for (int k = 0; k < 6; k++) car_x[k] <= start_x(k);
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_Start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            // A collision wins over a coincident tick: the cars stop where they are.
            if (bus.i_Has_Collided) begin
              state   <= FROZEN;
              frz_cnt <= FW'(FREEZE_TICKS);
              frozen  <= 1'b1;
              running <= 1'b0;
            end else if (tick) begin
              for (int k = 0; k < 6; k++)
                car_x[k] <= step_x(car_x[k], CAR_SPEED[4*k +: 4], CAR_DIR[k]);
            end
          end
          FROZEN: begin
            if (tick) begin
              frz_cnt <= frz_cnt - FW'(1);
              if (frz_cnt == FW'(1)) begin
                state   <= RUN;
                frozen  <= 1'b0;
                running <= 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            frozen  <= 1'b0;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_Car1_X    = car_x[0];
  assign bus.o_Car2_X    = car_x[1];
  assign bus.o_Car3_X    = car_x[2];
  assign bus.o_Car4_X    = car_x[3];
  assign bus.o_Car5_X    = car_x[4];
  assign bus.o_Car6_X    = car_x[5];
  assign bus.o_Move_Tick = move_tick;
  assign bus.o_Frozen    = frozen;
  assign bus.o_Running   = running;

endmodule

// File: tb/tb_car_traffic_gen.sv
// Directed plus randomized bench for car_traffic_gen against a cycle-level behavioural model
// that tracks game mode, remaining freeze ticks and car positions with modular arithmetic.
module tb_car_traffic_gen;
  localparam int          W  = 640;
  localparam int          TD = 4;
  localparam int          FT = 2;
  localparam logic [59:0] P_START = {10'd700, 10'd5, 10'd2, 10'd638, 10'd200, 10'd100};
  localparam logic [23:0] P_SPEED = {4'd15, 4'd5, 4'd5, 4'd5, 4'd0, 4'd3};
  localparam logic [5:0]  P_DIR   = 6'b000111;
  localparam logic [62:0] RST_EXP =
    {10'd60, 10'd5, 10'd2, 10'd638, 10'd200, 10'd100, 3'b000};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  car_traffic_gen_if bus();

  car_traffic_gen #(
    .SCREEN_WIDTH(W), .TICK_DIV(TD), .FREEZE_TICKS(FT),
    .CAR_START_X(P_START), .CAR_SPEED(P_SPEED), .CAR_DIR(P_DIR)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = idle, 1 = running, 2 = frozen.
  int m_mode, m_left, m_cyc;
  int m_x [6];
  bit m_mt;
  bit last_mt;

  task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] obs_vec();
    return {bus.o_Car6_X, bus.o_Car5_X, bus.o_Car4_X, bus.o_Car3_X, bus.o_Car2_X, bus.o_Car1_X,
            bus.o_Move_Tick, bus.o_Frozen, bus.o_Running};
  endfunction

  function automatic logic [62:0] exp_vec();
    logic [62:0] v;
    v = {60'd0, m_mt, (m_mode == 2), (m_mode == 1)};
    for (int k = 0; k < 6; k++) v[3 + 10*k +: 10] = 10'(m_x[k]);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_cyc = 0; m_mt = 1'b0;
    for (int k = 0; k < 6; k++) m_x[k] = int'(P_START[10*k +: 10]) % W;
  endtask

  task automatic model_step(input bit st, input bit rs, input bit co);
    bit tk;
    tk = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    m_mt = tk;
    if (rs) begin
      m_mode = 0; m_left = 0;
      for (int k = 0; k < 6; k++) m_x[k] = int'(P_START[10*k +: 10]) % W;
    end else if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (co) begin
        m_mode = 2; m_left = FT;
      end else if (tk) begin
        for (int k = 0; k < 6; k++) begin
          int s;
          s = int'(P_SPEED[4*k +: 4]);
          m_x[k] = P_DIR[k] ? (m_x[k] + s) % W : (m_x[k] - s + W) % W;
        end
      end
    end else if (tk) begin
      m_left--;
      if (m_left == 0) m_mode = 1;
    end
  endtask

  // Starts and ends at a falling edge; inputs are held across exactly one rising edge.
  task automatic cycle(input bit st, input bit rs, input bit co);
    bus.i_Start = st; bus.i_Restart = rs; bus.i_Has_Collided = co;
    @(posedge clk);
    model_step(st, rs, co);
    #1;
    last_mt = bus.o_Move_Tick;
    chk("model", obs_vec(), exp_vec());
    @(negedge clk);
    bus.i_Start = 1'b0; bus.i_Restart = 1'b0; bus.i_Has_Collided = 1'b0;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2*TD && !ok; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      ok = last_mt;
    end
    chk("tick_timeout", 63'(ok), 63'd1);
  endtask

  initial begin
    int cnt;
    bus.i_Start = 1'b0; bus.i_Restart = 1'b0; bus.i_Has_Collided = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_vals", obs_vec(), RST_EXP);
    model_reset();
    rst_n = 1'b1;

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      cnt += int'(last_mt);
    end
    chk("idle_tick_count", 63'(cnt), 63'd5);
    chk("idle_car1", 63'(bus.o_Car1_X), 63'd100);
    chk("idle_running", 63'(bus.o_Running), 63'd0);

    cycle(1'b1, 1'b0, 1'b0);
    chk("start_running", 63'(bus.o_Running), 63'd1);
    wait_tick();
    chk("car1_t1", 63'(bus.o_Car1_X), 63'd103);
    chk("car2_t1", 63'(bus.o_Car2_X), 63'd200);
    chk("wrap_right", 63'(bus.o_Car3_X), 63'd3);
    chk("wrap_left", 63'(bus.o_Car4_X), 63'd637);
    chk("left_to_zero", 63'(bus.o_Car5_X), 63'd0);
    wait_tick();
    chk("car1_t2", 63'(bus.o_Car1_X), 63'd106);
    chk("car2_t2", 63'(bus.o_Car2_X), 63'd200);

    while ((m_cyc % TD) != TD - 1) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("coll_tick_tick", 63'(last_mt), 63'd1);
    chk("coll_frozen", 63'(bus.o_Frozen), 63'd1);
    chk("coll_no_move", 63'(bus.o_Car1_X), 63'd106);
    wait_tick();
    chk("frz_t1_frozen", 63'(bus.o_Frozen), 63'd1);
    chk("frz_t1_hold", 63'(bus.o_Car1_X), 63'd106);
    wait_tick();
    chk("frz_t2_running", 63'(bus.o_Running), 63'd1);
    chk("frz_t2_hold", 63'(bus.o_Car1_X), 63'd106);
    wait_tick();
    chk("resume_move", 63'(bus.o_Car1_X), 63'd109);

    cycle(1'b0, 1'b0, 1'b1);
    chk("refreeze", 63'(bus.o_Frozen), 63'd1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("restart_frozen", 63'(bus.o_Frozen), 63'd0);
    chk("restart_running", 63'(bus.o_Running), 63'd0);
    chk("restart_car1", 63'(bus.o_Car1_X), 63'd100);
    chk("restart_car6", 63'(bus.o_Car6_X), 63'd60);

    for (int i = 0; i < 400; i++)
      cycle(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 12) == 0);

    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_running", 63'(bus.o_Running), 63'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs_vec(), RST_EXP);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
